// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing one fixed-latency memory between fetch and data paths.
// Define MEM_ARB_RR_EN for round-robin ties; otherwise data requests win ties.
module mem_arbiter #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_ack_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_ack_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o
);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t      state, state_nx;
    logic        grant, grant_dm;
    logic        owner_dm, we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  cnt;

`ifdef MEM_ARB_RR_EN
    logic last_dm;

    // On a tie, the requester that did not win last time gets the memory.
    always_comb grant_dm = dm_req_i & (~if_req_i | ~last_dm);

    always_ff @(posedge clk_i) begin
        if (rst_i)
            last_dm <= 1'b0;
        else if (grant)
            last_dm <= grant_dm;
    end
`else
    always_comb grant_dm = dm_req_i;
`endif

    always_comb grant = (state == IDLE) & (if_req_i | dm_req_i);

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (if_req_i | dm_req_i) state_nx = BUSY;
            BUSY:    if (cnt == 4'd1) state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Acks are set on the commit edge so they are high exactly in ACK.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt        <= '0;
            owner_dm   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_data_o  <= '0;
            dm_rdata_o <= '0;
            if_ack_o   <= 1'b0;
            dm_ack_o   <= 1'b0;
        end else begin
            if_ack_o <= 1'b0;
            dm_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner_dm <= grant_dm;
                        we_q     <= grant_dm & dm_we_i;
                        addr_q   <= grant_dm ? dm_addr_i : if_addr_i;
                        wdata_q  <= grant_dm ? dm_wdata_i : '0;
                        cnt      <= 4'(MEM_LAT);
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        if (owner_dm) begin
                            dm_ack_o <= 1'b1;
                            if (!we_q)
                                dm_rdata_o <= mem_rdata_i;
                        end else begin
                            if_ack_o  <= 1'b1;
                            if_data_o <= mem_rdata_i;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_en_o    = (state == BUSY);
        mem_we_o    = (state == BUSY) & we_q & (cnt == 4'd1);
        mem_addr_o  = (state == BUSY) ? addr_q  : '0;
        mem_wdata_o = (state == BUSY) ? wdata_q : '0;
        stall_o     = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer sharing one single-ported, fixed-latency unified memory between the instruction-fetch path and the data-memory path of the pipelined CPU. It grants one requester at a time and drives the memory for exactly MEM_LAT cycles. It returns read data with a one-cycle acknowledge pulse and raises a pipeline stall while any request is outstanding. It sits between the CPU datapath (PC/instruction fetch, MEM stage) and the memory model.

## Interface
Parameters:
- MEM_LAT, 2: memory access latency in cycles; legal range 1..15.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- if_req_i  in  1  fetch request; held high until if_ack_o.
- if_addr_i  in  32  fetch byte address.
- if_data_o  out  32  fetched word; valid in the if_ack_o cycle, held afterwards.
- if_ack_o  out  1  one-cycle completion pulse for fetch.
- dm_req_i  in  1  data request; held high until dm_ack_o.
- dm_we_i  in  1  1 = write, 0 = read.
- dm_addr_i  in  32  data byte address.
- dm_wdata_i  in  32  write data.
- dm_rdata_o  out  32  read data; updated only by reads, held otherwise.
- dm_ack_o  out  1  one-cycle completion pulse for data.
- mem_en_o  out  1  memory access enable.
- mem_we_o  out  1  memory write strobe.
- mem_addr_o  out  32  memory address.
- mem_wdata_o  out  32  memory write data.
- mem_rdata_i  in  32  memory read data; valid in the last enabled cycle of an access.
- stall_o  out  1  pipeline stall request.

## Operation
FSM states:
- IDLE
  - No request: stay.
  - Any request: grant one requester.
  - On the grant edge, latch owner, we, addr and wdata into registers, load cnt = MEM_LAT, and go to BUSY.
- BUSY
  - mem_en_o = 1; mem_addr_o, mem_wdata_o and mem_we_o come from the latched values.
  - mem_we_o is asserted only when cnt == 1, which is the commit cycle.
  - cnt decrements each cycle.
  - When cnt == 1: capture mem_rdata_i into the owner's data register (reads only) and go to ACK.
- ACK
  - Owner's ack output = 1.
  - Requests are ignored.
  - Go to IDLE.

Arbitration:
- Without the macro, dm_req_i always beats if_req_i, because the MEM-stage instruction is older.

Request handling:
- Request inputs that change after the grant are ignored.
- A requester dropping req mid-access does not abort the access; the ack still pulses.

stall_o:
- stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o). It is combinational from the inputs and registered acks.

Counter:
- Width 4 bits, which covers MEM_LAT ≤ 15.
- It never underflows, because state leaves BUSY when cnt == 1.

Reset:
- rst_i high at an edge, from any state, gives IDLE on the next cycle.
- Outputs after reset: cnt = 0, all acks = 0, mem_en_o = mem_we_o = 0, mem_addr_o = mem_wdata_o = 0, if_data_o = dm_rdata_o = 0.
- Round-robin pointer after reset: "last = IF".
- Reset before the commit cycle guarantees no memory write and no ack.

## Timing
- Request seen in IDLE at cycle t:
  - BUSY during cycles t+1 .. t+MEM_LAT.
  - Ack at cycle t+MEM_LAT+1.
  - IDLE at t+MEM_LAT+2.
- Minimum occupancy per access: MEM_LAT+2 cycles. A second requester waiting through an access is granted at the IDLE cycle that follows.
- Ack outputs are registered and have no combinational path from request inputs.
- stall_o is low in the ack cycle of a lone requester. It stays high for a requester that is still waiting.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - When both requests are high in IDLE, grant the requester not granted last.
  - The pointer updates at each grant and resets to "last = IF", so DM wins the first tie.
  - Single requests are always granted.
- MEM_ARB_RR_EN undefined: fixed priority, DM over IF.
  - No pointer register exists.

## Test plan
- Reset: rst_i = 1 for 2 cycles during a BUSY access -> next cycle all outputs 0, mem_en_o = 0, no ack ever issued for that access.
- Lone fetch, MEM_LAT = 2: if_req_i = 1, if_addr_i = 0x10 at cycle 0, mem_rdata_i = 0xDEADBEEF -> mem_en_o = 1 and mem_addr_o = 0x10 in cycles 1-2; if_ack_o = 1 and if_data_o = 0xDEADBEEF in cycle 3; stall_o = 1 in cycles 0-2 and 0 in cycle 3.
- Tie, macro undefined: both req at cycle 0 and held -> dm_ack_o at cycle 3, if_ack_o at cycle 7; stall_o high continuously through cycle 6.
- Tie, MEM_ARB_RR_EN defined: both requesters reissue immediately after each ack for 4 accesses -> ack order DM, IF, DM, IF.
- Write: dm_we_i = 1, dm_addr_i = 0x20, dm_wdata_i = 0x1234 at cycle 0 -> mem_we_o = 1 only in cycle 2 with mem_addr_o = 0x20 and mem_wdata_o = 0x1234; dm_ack_o at cycle 3; dm_rdata_o unchanged.
- Abort: dm write granted at cycle 0, rst_i = 1 at cycle 1 -> IDLE at cycle 2, mem_we_o never asserted, dm_ack_o never asserted.
